// File: rtl/zbuf_rmw_unit.sv
`default_nettype none
// ============================================================================
// Module : zbuf_rmw_unit -- FIFO-buffered depth-tested pixel writer and frame clear
// Option : define ZBUF_STATS_EN to add the oWRITE_CNT / oDISCARD_CNT counters
// Rev    : 1.0
// ============================================================================
module zbuf_rmw_unit #(
  parameter int DEPTH_W    = 2,
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 18,
  parameter int H_RES      = 640,
  parameter int V_RES      = 400,
  parameter int FIFO_DEPTH = 4,
  parameter logic [DEPTH_W-1:0] CLEAR_DEPTH = '1
) (
  input  logic                       iCLK,
  input  logic                       reset,
  input  logic                       iPIX_VALID,
  output logic                       oPIX_READY,
  input  logic [9:0]                 iPIX_X,
  input  logic [9:0]                 iPIX_Y,
  input  logic [DEPTH_W-1:0]         iPIX_DEPTH,
  input  logic [DATA_W-DEPTH_W-1:0]  iPIX_COLOR,
  input  logic [1:0]                 iCMP_MODE,
  input  logic                       iCLEAR_REQ,
  output logic                       oCLEAR_BUSY,
  input  logic                       iVIDEO_ON,
  output logic [ADDR_W-1:0]          oMEM_ADDR,
  output logic                       oMEM_READ,
  output logic                       oMEM_WRITE,
  output logic [DATA_W-1:0]          oGPU_DATA,
  input  logic [DATA_W-1:0]          iGPU_DATA,
`ifdef ZBUF_STATS_EN
  output logic [15:0]                oWRITE_CNT,
  output logic [15:0]                oDISCARD_CNT,
`endif
  output logic                       oIDLE
);

  localparam int COLOR_W = DATA_W - DEPTH_W;
  localparam int ENT_W   = 20 + DATA_W;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]    c_fifo_full = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] c_h_res     = ADDR_W'(H_RES);
  localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(H_RES * V_RES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_CMP   = 3'd2,
    S_WRITE = 3'd3,
    S_CLEAR = 3'd4
  } state_t;

  state_t r_state, w_state_nxt;

  logic [ENT_W-1:0]   r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]     r_count;
  logic               w_push, w_pop;
  logic [ENT_W-1:0]   w_head;
  logic [9:0]         w_head_x, w_head_y;
  logic [DEPTH_W-1:0] w_head_depth;
  logic [COLOR_W-1:0] w_head_color;
  logic               w_head_in_range;
  logic [ADDR_W-1:0]  w_head_addr;

  logic [ADDR_W-1:0]  r_addr, w_addr_nxt;
  logic               r_read, w_read_nxt;
  logic               r_write, w_write_nxt;
  logic [DATA_W-1:0]  r_wdata, w_wdata_nxt;
  logic               r_busy;
  logic [DEPTH_W-1:0] r_depth;
  logic [COLOR_W-1:0] r_color;
  logic [1:0]         r_mode;
  logic               w_latch, w_busy_clr, w_clear_entry, w_pass_evt, w_drop_evt;
  logic [DEPTH_W-1:0] w_stored_depth;
  logic               w_pass;

  // Pixel FIFO: ready looks only at the registered count, never at this cycle's pop
  assign oPIX_READY = (r_count != c_fifo_full);
  assign w_push     = iPIX_VALID && oPIX_READY;
  assign w_head     = r_fifo[r_rd_ptr];
  assign {w_head_x, w_head_y, w_head_depth, w_head_color} = w_head;
  assign w_head_in_range = (int'(w_head_x) < H_RES) && (int'(w_head_y) < V_RES);
  assign w_head_addr     = ADDR_W'(w_head_y) * c_h_res + ADDR_W'(w_head_x);

  always_ff @(posedge iCLK) begin
    if (w_push) r_fifo[r_wr_ptr] <= {iPIX_X, iPIX_Y, iPIX_DEPTH, iPIX_COLOR};
  end

  always_ff @(posedge iCLK or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  assign w_stored_depth = iGPU_DATA[DATA_W-1 -: DEPTH_W];

  always_comb begin
    w_pass = 1'b0;
    case (r_mode)
      2'd0:    w_pass = (r_depth <  w_stored_depth);
      2'd1:    w_pass = (r_depth <= w_stored_depth);
      2'd2:    w_pass = 1'b1;
      default: w_pass = (r_depth >  w_stored_depth);
    endcase
  end

  always_ff @(posedge iCLK or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state plus next value of every registered memory output
  always_comb begin
    w_state_nxt   = r_state;
    w_addr_nxt    = r_addr;
    w_read_nxt    = 1'b0;
    w_write_nxt   = 1'b0;
    w_wdata_nxt   = r_wdata;
    w_pop         = 1'b0;
    w_latch       = 1'b0;
    w_busy_clr    = 1'b0;
    w_clear_entry = 1'b0;
    w_pass_evt    = 1'b0;
    w_drop_evt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!iVIDEO_ON) begin
          if (r_busy) begin
            w_state_nxt   = S_CLEAR;
            w_addr_nxt    = '0;
            w_write_nxt   = 1'b1;
            w_wdata_nxt   = {CLEAR_DEPTH, {COLOR_W{1'b0}}};
            w_clear_entry = 1'b1;
          end else if (r_count != '0) begin
            w_pop = 1'b1;
            if (w_head_in_range) begin
              w_latch     = 1'b1;
              w_state_nxt = S_READ;
              w_addr_nxt  = w_head_addr;
              w_read_nxt  = 1'b1;
            end else begin
              w_drop_evt = 1'b1;
            end
          end
        end
      end
      S_READ: w_state_nxt = S_CMP;
      S_CMP: begin
        if (w_pass) begin
          w_state_nxt = S_WRITE;
          w_write_nxt = 1'b1;
          w_wdata_nxt = {r_depth, r_color};
          w_pass_evt  = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
          w_drop_evt  = 1'b1;
        end
      end
      S_WRITE: w_state_nxt = S_IDLE;
      S_CLEAR: begin
        // While paused, r_addr holds the next address still to be written
        if (r_write) begin
          if (r_addr == c_last_addr) begin
            w_state_nxt = S_IDLE;
            w_busy_clr  = 1'b1;
          end else begin
            w_addr_nxt  = r_addr + 1'b1;
            w_write_nxt = !iVIDEO_ON;
          end
        end else begin
          w_write_nxt = !iVIDEO_ON;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or posedge reset) begin
    if (reset) begin
      r_addr  <= '0;
      r_read  <= 1'b0;
      r_write <= 1'b0;
      r_wdata <= '0;
      r_busy  <= 1'b0;
      r_depth <= '0;
      r_color <= '0;
      r_mode  <= 2'd0;
    end else begin
      r_addr  <= w_addr_nxt;
      r_read  <= w_read_nxt;
      r_write <= w_write_nxt;
      r_wdata <= w_wdata_nxt;
      if (w_busy_clr)      r_busy <= 1'b0;
      else if (iCLEAR_REQ) r_busy <= 1'b1;
      if (w_latch) begin
        r_depth <= w_head_depth;
        r_color <= w_head_color;
        r_mode  <= iCMP_MODE;
      end
    end
  end

  assign oMEM_ADDR   = r_addr;
  assign oMEM_READ   = r_read;
  assign oMEM_WRITE  = r_write;
  assign oGPU_DATA   = r_wdata;
  assign oCLEAR_BUSY = r_busy;
  assign oIDLE       = (r_state == S_IDLE) && (r_count == '0) && !r_busy;

`ifdef ZBUF_STATS_EN
  logic [15:0] r_write_cnt, r_discard_cnt;
  logic        w_unused;

  always_ff @(posedge iCLK or posedge reset) begin
    if (reset) begin
      r_write_cnt   <= '0;
      r_discard_cnt <= '0;
    end else if (w_clear_entry) begin
      r_write_cnt   <= '0;
      r_discard_cnt <= '0;
    end else begin
      if (w_pass_evt && r_write_cnt != 16'hFFFF)   r_write_cnt   <= r_write_cnt + 1'b1;
      if (w_drop_evt && r_discard_cnt != 16'hFFFF) r_discard_cnt <= r_discard_cnt + 1'b1;
    end
  end

  assign oWRITE_CNT   = r_write_cnt;
  assign oDISCARD_CNT = r_discard_cnt;
  assign w_unused     = ^iGPU_DATA[COLOR_W-1:0];
`else
  logic w_unused;
  assign w_unused = ^{iGPU_DATA[COLOR_W-1:0], w_pass_evt, w_drop_evt, w_clear_entry};
`endif

endmodule
`default_nettype wire

// File: tb/tb_zbuf_rmw_unit.sv
`default_nettype none
// Bench for zbuf_rmw_unit: 640x4 frame, scoreboard of expected SRAM accesses
// checked by an independent monitor, plus directed latency and status checks.
module tb_zbuf_rmw_unit;

  localparam int NWORDS = 640 * 4;

  logic        iCLK = 1'b0;
  logic        reset;
  logic        iPIX_VALID;
  logic        oPIX_READY;
  logic [9:0]  iPIX_X, iPIX_Y;
  logic [1:0]  iPIX_DEPTH;
  logic [13:0] iPIX_COLOR;
  logic [1:0]  iCMP_MODE;
  logic        iCLEAR_REQ;
  logic        oCLEAR_BUSY;
  logic        iVIDEO_ON;
  logic [17:0] oMEM_ADDR;
  logic        oMEM_READ, oMEM_WRITE;
  logic [15:0] oGPU_DATA;
  logic [15:0] iGPU_DATA;
  logic        oIDLE;
`ifdef ZBUF_STATS_EN
  logic [15:0] oWRITE_CNT, oDISCARD_CNT;
`endif

  zbuf_rmw_unit #(
    .H_RES(640), .V_RES(4), .FIFO_DEPTH(4)
  ) dut (
    .iCLK(iCLK), .reset(reset),
    .iPIX_VALID(iPIX_VALID), .oPIX_READY(oPIX_READY),
    .iPIX_X(iPIX_X), .iPIX_Y(iPIX_Y), .iPIX_DEPTH(iPIX_DEPTH), .iPIX_COLOR(iPIX_COLOR),
    .iCMP_MODE(iCMP_MODE), .iCLEAR_REQ(iCLEAR_REQ), .oCLEAR_BUSY(oCLEAR_BUSY),
    .iVIDEO_ON(iVIDEO_ON), .oMEM_ADDR(oMEM_ADDR), .oMEM_READ(oMEM_READ),
    .oMEM_WRITE(oMEM_WRITE), .oGPU_DATA(oGPU_DATA), .iGPU_DATA(iGPU_DATA),
`ifdef ZBUF_STATS_EN
    .oWRITE_CNT(oWRITE_CNT), .oDISCARD_CNT(oDISCARD_CNT),
`endif
    .oIDLE(oIDLE)
  );

  always #5 iCLK = ~iCLK;

  // SRAM model: read data appears the cycle after the read strobe
  logic [15:0] mem [0:NWORDS-1];
  logic        poke_en;
  logic [11:0] poke_addr;
  logic [15:0] poke_data;
  always @(posedge iCLK) begin
    if (poke_en) mem[poke_addr] <= poke_data;
    else if (oMEM_WRITE && oMEM_ADDR < NWORDS) mem[oMEM_ADDR[11:0]] <= oGPU_DATA;
    if (oMEM_READ) iGPU_DATA <= (oMEM_ADDR < NWORDS) ? mem[oMEM_ADDR[11:0]] : 16'hDEAD;
  end

  typedef struct packed { logic wr; logic [17:0] addr; logic [15:0] data; } txn_t;
  txn_t exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic exp_push(input logic wr, input logic [17:0] a, input logic [15:0] d);
    txn_t t;
    t.wr = wr; t.addr = a; t.data = d;
    exp_q.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe cycle must match the head of the expected queue
  initial begin
    txn_t t;
    forever begin
      @(negedge iCLK);
      if (!reset && (oMEM_READ || oMEM_WRITE)) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL strobe_unexpected: got rd=%0b wr=%0b addr=%0d data=%h, want no access",
                   oMEM_READ, oMEM_WRITE, oMEM_ADDR, oGPU_DATA);
        end else begin
          t = exp_q.pop_front();
          if (oMEM_READ == t.wr || oMEM_WRITE != t.wr || oMEM_ADDR != t.addr ||
              (t.wr && oGPU_DATA != t.data)) begin
            bad++;
            $display("FAIL mem_access: got rd=%0b wr=%0b addr=%0d data=%h want wr=%0b addr=%0d data=%h",
                     oMEM_READ, oMEM_WRITE, oMEM_ADDR, oGPU_DATA, t.wr, t.addr, t.data);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic push_pixel(input logic [9:0] x, input logic [9:0] y,
                            input logic [1:0] d, input logic [13:0] c);
    int  n;
    bit  acc;
    iPIX_X = x; iPIX_Y = y; iPIX_DEPTH = d; iPIX_COLOR = c; iPIX_VALID = 1'b1;
    n = 0;
    do begin
      acc = oPIX_READY;
      tick();
      n++;
    end while (!acc && n < 50);
    iPIX_VALID = 1'b0;
    if (!acc) begin
      total++; bad++;
      $display("FAIL push_timeout: got ready=0 for 50 cycles want accept");
    end
  endtask

  // nstrobe: 0 none, 1 read only, 2 read then write
  task automatic do_pixel(input string name, input logic [9:0] x, input logic [9:0] y,
                          input logic [1:0] d, input logic [13:0] c, input logic [1:0] mode,
                          input logic [15:0] stored, input int nstrobe,
                          input logic [17:0] a, input logic [15:0] wd, input int cyc);
    int n;
    if (nstrobe > 0) begin
      poke_en = 1'b1; poke_addr = a[11:0]; poke_data = stored;
      tick();
      poke_en = 1'b0;
      exp_push(1'b0, a, 16'h0);
      if (nstrobe > 1) exp_push(1'b1, a, wd);
    end
    iCMP_MODE = mode;
    push_pixel(x, y, d, c);
    n = 0;
    while (!oIDLE && n < 50) begin
      tick();
      n++;
    end
    chk({name, "_cycles"}, n, cyc);
  endtask

  task automatic start_clear();
    for (int i = 0; i < NWORDS; i++) exp_push(1'b1, 18'(i), 16'hC000);
    iCLEAR_REQ = 1'b1;
    tick();
    iCLEAR_REQ = 1'b0;
  endtask

  initial begin
    int n, acc_cnt;
    bit acc;
    reset = 1'b1; iPIX_VALID = 1'b0; iPIX_X = '0; iPIX_Y = '0; iPIX_DEPTH = '0;
    iPIX_COLOR = '0; iCMP_MODE = 2'd0; iCLEAR_REQ = 1'b0; iVIDEO_ON = 1'b0;
    poke_en = 1'b0; poke_addr = '0; poke_data = '0;
    repeat (3) tick();
    chk("rst_addr", oMEM_ADDR, 0);
    chk("rst_read", oMEM_READ, 0);
    chk("rst_write", oMEM_WRITE, 0);
    chk("rst_data", oGPU_DATA, 0);
    chk("rst_busy", oCLEAR_BUSY, 0);
    chk("rst_ready", oPIX_READY, 1);
    chk("rst_idle", oIDLE, 1);
    reset = 1'b0;
    tick();

    // Full blanked clear; a second request mid-clear must not queue another
    start_clear();
    chk("clear_busy_rise", oCLEAR_BUSY, 1);
    n = 0;
    while (oCLEAR_BUSY && n < 3000) begin
      iCLEAR_REQ = (n == 100);
      tick();
      n++;
    end
    iCLEAR_REQ = 1'b0;
    chk("clear_cycles", n, NWORDS + 1);
    repeat (5) tick();
    chk("clear_idle", oIDLE, 1);
    chk("clear_drained", exp_q.size(), 0);

    // Depth compare modes on pixel (10,2), depth 1, colour 0FFF -> addr 1290, word 4FFF
    do_pixel("lequal_far",  10, 2, 2'd1, 14'h0FFF, 2'd1, 16'hC000, 2, 18'd1290, 16'h4FFF, 4);
    do_pixel("lequal_eq",   10, 2, 2'd1, 14'h0FFF, 2'd1, 16'h4000, 2, 18'd1290, 16'h4FFF, 4);
    do_pixel("lequal_fail", 10, 2, 2'd1, 14'h0FFF, 2'd1, 16'h0000, 1, 18'd1290, 16'h0000, 3);
    do_pixel("less_eq",     10, 2, 2'd1, 14'h0FFF, 2'd0, 16'h4000, 1, 18'd1290, 16'h0000, 3);
    do_pixel("greater",     10, 2, 2'd1, 14'h0FFF, 2'd3, 16'h0000, 2, 18'd1290, 16'h4FFF, 4);
    do_pixel("always",      10, 2, 2'd1, 14'h0FFF, 2'd2, 16'h0000, 2, 18'd1290, 16'h4FFF, 4);
    do_pixel("last_addr",  639, 3, 2'd0, 14'h1234, 2'd0, 16'hC000, 2, 18'd2559, 16'h1234, 4);
    do_pixel("oor_x",      640, 0, 2'd0, 14'h0001, 2'd2, 16'h0000, 0, 18'd0,    16'h0000, 1);
    do_pixel("oor_y",        0, 4, 2'd0, 14'h0001, 2'd2, 16'h0000, 0, 18'd0,    16'h0000, 1);
`ifdef ZBUF_STATS_EN
    chk("stat_writes", oWRITE_CNT, 5);
    chk("stat_discards", oDISCARD_CNT, 4);
`endif

    // Back-pressure with video on: 4 of 6 accepted, then drained in push order
    iVIDEO_ON = 1'b1;
    iCMP_MODE = 2'd2;
    acc_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      iPIX_X = 10'(100 + k); iPIX_Y = 10'd3; iPIX_DEPTH = 2'(k);
      iPIX_COLOR = 14'h0100 + 14'(k); iPIX_VALID = 1'b1;
      acc = oPIX_READY;
      if (acc) begin
        exp_push(1'b0, 18'(2020 + k), 16'h0);
        exp_push(1'b1, 18'(2020 + k), {2'(k), 14'h0100 + 14'(k)});
        acc_cnt++;
      end
      tick();
    end
    iPIX_VALID = 1'b0;
    chk("fifo_accepts", acc_cnt, 4);
    chk("fifo_ready_full", oPIX_READY, 0);
    repeat (5) tick();
    chk("fifo_held", exp_q.size(), 8);
    iVIDEO_ON = 1'b0;
    n = 0;
    while (!oIDLE && n < 60) begin
      tick();
      n++;
    end
    chk("fifo_drain_cycles", n, 16);
    chk("fifo_drained", exp_q.size(), 0);

    // Video rises right after the write of address 999; resume must start at 1000
    start_clear();
    n = 0;
    while (!(oMEM_WRITE && oMEM_ADDR == 18'd999) && n < 2000) begin
      tick();
      n++;
    end
    chk("pause_reached", {31'b0, oMEM_WRITE}, 1);
    iVIDEO_ON = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("pause_no_write", oMEM_WRITE, 0);
    end
    chk("pause_addr", oMEM_ADDR, 1000);
    chk("pause_busy", oCLEAR_BUSY, 1);
    iVIDEO_ON = 1'b0;
    n = 0;
    while (oCLEAR_BUSY && n < 3000) begin
      tick();
      n++;
    end
    chk("pause_clear_done", oCLEAR_BUSY, 0);
    chk("pause_drained", exp_q.size(), 0);

    // Reset in the middle of a clear
    start_clear();
    repeat (50) tick();
    reset = 1'b1;
    #1;
    chk("midrst_write", oMEM_WRITE, 0);
    chk("midrst_addr", oMEM_ADDR, 0);
    chk("midrst_data", oGPU_DATA, 0);
    chk("midrst_busy", oCLEAR_BUSY, 0);
    exp_q.delete();
    tick();
    tick();
    reset = 1'b0;
    repeat (10) tick();
    chk("postrst_busy", oCLEAR_BUSY, 0);
    chk("postrst_idle", oIDLE, 1);
    chk("final_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
